// File: rtl/l2_mem_ctrl.sv
// Shared L2 memory controller: round-robin arbitration between icache and dcache
// onto a single-port SRAM with a fixed 4-cycle IDLE/ISSUE/WAIT/RESP access sequence.
module l2_mem_ctrl #(
   parameter int MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_valid_i,
   input  logic [31:0]       icache_addr_i,
   output logic              icache_valid_o,
   output logic [31:0]       icache_dat_o,
   input  logic              dcache_valid_i,
   input  logic [31:0]       dcache_addr_i,
   input  logic              dcache_we_i,
   input  logic [31:0]       dcache_dat_i,
   output logic              dcache_valid_o,
   output logic [31:0]       dcache_dat_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [31:0]       mem_wdat_o,
   input  logic [31:0]       mem_rdat_i
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              w_req_any;
   logic              w_grant_dc;
   logic              r_last_dc;
   logic              r_req_dc;
   logic              r_req_we;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [MEM_AW-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdat;
   logic              r_icache_valid;
   logic [31:0]       r_icache_dat;
   logic              r_dcache_valid;
   logic [31:0]       r_dcache_dat;
   logic              w_unused;

   assign w_unused = ^{icache_addr_i[31:MEM_AW+2], icache_addr_i[1:0],
                       dcache_addr_i[31:MEM_AW+2], dcache_addr_i[1:0]};

   // Arbitration: on a tie, the channel that did not win last time is granted.
   always_comb begin
      w_req_any  = icache_valid_i | dcache_valid_i;
      w_grant_dc = dcache_valid_i & (~icache_valid_i | ~r_last_dc);
   end

   // Next-state logic for the fixed access sequence.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = ST_ISSUE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT:  w_state_nxt = ST_RESP;
         ST_RESP:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State, latched request and registered SRAM/response outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_last_dc      <= 1'b1;
         r_req_dc       <= 1'b0;
         r_req_we       <= 1'b0;
         r_mem_en       <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= {MEM_AW{1'b0}};
         r_mem_wdat     <= 32'h0;
         r_icache_valid <= 1'b0;
         r_icache_dat   <= 32'h0;
         r_dcache_valid <= 1'b0;
         r_dcache_dat   <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_req_any) begin
                  r_req_dc   <= w_grant_dc;
                  r_last_dc  <= w_grant_dc;
                  r_req_we   <= w_grant_dc & dcache_we_i;
                  r_mem_en   <= 1'b1;
                  r_mem_we   <= w_grant_dc & dcache_we_i;
                  r_mem_addr <= w_grant_dc ? dcache_addr_i[MEM_AW+1:2]
                                           : icache_addr_i[MEM_AW+1:2];
                  r_mem_wdat <= w_grant_dc ? dcache_dat_i : 32'h0;
               end
            end
            ST_ISSUE: begin
               r_mem_en   <= 1'b0;
               r_mem_we   <= 1'b0;
               r_mem_addr <= {MEM_AW{1'b0}};
               r_mem_wdat <= 32'h0;
            end
            // SRAM read data is valid here; writes return zero.
            ST_WAIT: begin
               if (r_req_dc) begin
                  r_dcache_valid <= 1'b1;
                  r_dcache_dat   <= r_req_we ? 32'h0 : mem_rdat_i;
               end else begin
                  r_icache_valid <= 1'b1;
                  r_icache_dat   <= mem_rdat_i;
               end
            end
            ST_RESP: begin
               r_icache_valid <= 1'b0;
               r_icache_dat   <= 32'h0;
               r_dcache_valid <= 1'b0;
               r_dcache_dat   <= 32'h0;
               r_req_dc       <= 1'b0;
               r_req_we       <= 1'b0;
            end
            default: begin
               r_mem_en       <= 1'b0;
               r_mem_we       <= 1'b0;
               r_icache_valid <= 1'b0;
               r_dcache_valid <= 1'b0;
            end
         endcase
      end
   end

   assign icache_valid_o = r_icache_valid;
   assign icache_dat_o   = r_icache_dat;
   assign dcache_valid_o = r_dcache_valid;
   assign dcache_dat_o   = r_dcache_dat;
   assign mem_en_o       = r_mem_en;
   assign mem_we_o       = r_mem_we;
   assign mem_addr_o     = r_mem_addr;
   assign mem_wdat_o     = r_mem_wdat;

endmodule

// File: doc/l2_mem_ctrl.md
L2_MEM_CTRL -- requirements
Module: l2_mem_ctrl

Interface
REQ-001 Parameter MEM_AW, default 14: word-address width of the backing SRAM (64 KiB at default).
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 icache_valid_i  input  1  instruction fetch request, level-held until acked.
REQ-006 icache_addr_i  input  32  instruction byte address.
REQ-007 icache_valid_o  output  1  one-cycle instruction response pulse.
REQ-008 icache_dat_o  output  32  instruction word, meaningful only with icache_valid_o.
REQ-009 dcache_valid_i  input  1  data request, level-held until acked.
REQ-010 dcache_addr_i  input  32  data byte address.
REQ-011 dcache_we_i  input  1  1 = write, 0 = read.
REQ-012 dcache_dat_i  input  32  write data.
REQ-013 dcache_valid_o  output  1  one-cycle data response/ack pulse.
REQ-014 dcache_dat_o  output  32  read data, meaningful only with dcache_valid_o.
REQ-015 mem_en_o  output  1  SRAM access enable.
REQ-016 mem_we_o  output  1  SRAM write enable.
REQ-017 mem_addr_o  output  MEM_AW  SRAM word address.
REQ-018 mem_wdat_o  output  32  SRAM write data.
REQ-019 mem_rdat_i  input  32  SRAM read data, valid the cycle after a read with mem_en_o=1.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; sequence IDLE->ISSUE->WAIT->RESP->IDLE, with no other transitions.
REQ-021 IDLE: a request with valid_i=1 sampled at an edge SHALL be granted, and the FSM SHALL move to ISSUE; with no request, the FSM SHALL stay in IDLE.
REQ-022 At grant, addr, we and wdat SHALL be latched; later input changes SHALL be ignored until the next grant.
REQ-023 Arbitration: single requester wins; when both are valid, grant SHALL go to the channel not granted last (round-robin); the last-grant pointer SHALL update on every grant.
REQ-024 ISSUE: mem_en_o=1, mem_addr_o=latched addr[MEM_AW+1:2], mem_we_o=latched we (icache always 0), mem_wdat_o=latched wdat; addr[1:0] and bits above MEM_AW+1 SHALL be ignored.
REQ-025 WAIT: mem_en_o=0; mem_rdat_i SHALL be captured into the response register for reads, and 32'h0 for writes.
REQ-026 RESP: the granted channel's valid_o=1 for exactly one cycle, with dat_o=captured data; the other channel's valid_o/dat_o SHALL stay 0.
REQ-027 Latency: request sampled in IDLE at cycle C -> mem_en_o at C+1 -> response pulse at C+3; a new grant is possible at C+4 (4-cycle throughput per access).
REQ-028 The requester SHALL deassert valid_i in the cycle after its response pulse; a valid_i still high in IDLE at C+4 SHALL be treated as a new request.
REQ-029 Whenever not in RESP, all valid_o and dat_o SHALL be 0; mem_* outputs SHALL be 0 outside ISSUE.
REQ-030 A request arriving while the FSM is busy SHALL be held off, not dropped, and served at the next IDLE per REQ-023.

Reset
REQ-031 With rst_n=0 at an edge: FSM->IDLE, all outputs 0, latched request and response register cleared, last-grant pointer = dcache (icache wins the first tie).
REQ-032 Reset asserted mid-transaction (ISSUE/WAIT/RESP) SHALL abort it with no response pulse; a write in ISSUE at that edge SHALL not be issued after reset.

Verification
REQ-033 Icache read at 0x0000_0010, SRAM word 4 = 0xDEADBEEF -> mem_en_o=1, mem_addr_o=4 at C+1; icache_valid_o=1, icache_dat_o=0xDEADBEEF at C+3 only.
REQ-034 Dcache write addr 0x0000_0104, data 0x12345678 -> mem_we_o=1, mem_addr_o=0x41, mem_wdat_o=0x12345678 at C+1; dcache_valid_o=1, dcache_dat_o=0 at C+3.
REQ-035 Both valid in the first cycle after reset -> icache served first (pulse C+3), dcache granted at C+4 (pulse C+7), next tie goes to icache.
REQ-036 Dcache addr changed from 0x8 to 0xC during ISSUE -> mem_addr_o stays 2; returned data is from word 2.
REQ-037 rst_n=0 in WAIT of a dcache read -> no dcache_valid_o pulse; all outputs 0 the cycle after; a fresh icache request completes with normal C+3 latency.
REQ-038 Address 0xFFFF_FFFC with MEM_AW=14 -> mem_addr_o=14'h3FFF.
